// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter that shares one external SR flag flop among NREQ
// requesters. Each transaction drives a one-cycle set or reset pulse,
// reads the flop back one cycle later, and acknowledges the winner.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for any req; picks the RR winner, launches s/r pulse
// DRIVE | gnt and s/r high for one cycle; flop captures at cycle end
// CHECK | compare q_in against captured op, pulse ack, advance pointer
module sr_flag_arbiter #(
   parameter int NREQ = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic [NREQ-1:0] op,
   input  logic            q_in,
   output logic            s,
   output logic            r,
   output logic [NREQ-1:0] gnt,
   output logic [NREQ-1:0] ack,
   output logic            busy,
   output logic            err
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      CHECK = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   owner;
   logic            exp_op;
   logic [PW-1:0]   win;
   logic            win_vld;

   logic            s_nxt;
   logic            r_nxt;
   logic [NREQ-1:0] gnt_nxt;
   logic [NREQ-1:0] ack_nxt;
   logic            err_nxt;
   logic [PW-1:0]   ptr_nxt;
   logic [PW-1:0]   owner_nxt;
   logic            exp_nxt;

   // Round-robin search: first set req bit at or above ptr, wrapping.
   always_comb begin
      int            idx;
      logic [PW-1:0] idx_b;
      win     = '0;
      win_vld = 1'b0;
      idx     = 0;
      idx_b   = '0;
      for (int i = 0; i < NREQ; i++) begin
         idx = int'(ptr) + i;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
         idx_b = idx[PW-1:0];
         if (!win_vld && req[idx_b]) begin
            win_vld = 1'b1;
            win     = idx_b;
         end
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: fixed IDLE -> DRIVE -> CHECK -> IDLE path.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (win_vld) state_nxt = DRIVE;
         DRIVE:   state_nxt = CHECK;
         CHECK:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output/datapath next values; s and r are derived from one op bit so
   // they can never be high together.
   always_comb begin
      s_nxt     = 1'b0;
      r_nxt     = 1'b0;
      gnt_nxt   = '0;
      ack_nxt   = '0;
      err_nxt   = err;
      ptr_nxt   = ptr;
      owner_nxt = owner;
      exp_nxt   = exp_op;
      case (state)
         IDLE: begin
            if (win_vld) begin
               owner_nxt    = win;
               exp_nxt      = op[win];
               gnt_nxt[win] = 1'b1;
               s_nxt        = op[win];
               r_nxt        = ~op[win];
            end
         end
         CHECK: begin
            if (q_in != exp_op) begin
               err_nxt = 1'b1;
            end
            ack_nxt[owner] = 1'b1;
            if (owner == PW'(NREQ - 1)) begin
               ptr_nxt = '0;
            end else begin
               ptr_nxt = owner + 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Output and datapath registers; reset drops s/r immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s      <= 1'b0;
         r      <= 1'b0;
         gnt    <= '0;
         ack    <= '0;
         err    <= 1'b0;
         ptr    <= '0;
         owner  <= '0;
         exp_op <= 1'b0;
      end else begin
         s      <= s_nxt;
         r      <= r_nxt;
         gnt    <= gnt_nxt;
         ack    <= ack_nxt;
         err    <= err_nxt;
         ptr    <= ptr_nxt;
         owner  <= owner_nxt;
         exp_op <= exp_nxt;
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: doc/sr_flag_arbiter.md
Name: sr_flag_arbiter

Overview:
- Shares one SR flip-flop status flag among NREQ requesters. Each requester asks to set or reset the flag.
- Round-robin arbitration grants one request at a time.
- The block drives single-cycle s/r pulses into the flag flop. It guarantees s and r are never asserted together.
- It reads back the flop's q to confirm each operation, then acknowledges the winning requester.

Parameters:
NREQ, 4, number of requesters (2..8)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
req  input  NREQ  per-requester request level; held until matching ack
op  input  NREQ  per-requester operation (1 = set flag, 0 = reset flag); held stable with req
q_in  input  1  q output of the controlled SR flip-flop (feedback)
s  output  1  set drive to SR flip-flop, registered
r  output  1  reset drive to SR flip-flop, registered
gnt  output  NREQ  one-hot grant, registered, high for exactly one cycle per transaction
ack  output  NREQ  one-hot completion pulse, registered, one cycle
busy  output  1  high whenever state is not IDLE
err  output  1  sticky: readback mismatch seen; cleared only by rst

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; s=0, r=0, gnt=0, ack=0, busy=0, err=0.
  - RR pointer=0, so requester 0 has highest priority.
  - Captured op and owner are cleared.
  - Reset asserted mid-transaction aborts it: no ack is issued, and s/r drop to 0 immediately.
- States: IDLE -> DRIVE -> CHECK -> IDLE. Fixed path, no early exit.
- IDLE:
  - Stays while req==0.
  - If any req bit is set at edge k, choose the winner w by searching from the pointer upward, wrapping modulo NREQ.
  - At edge k: latch owner=w and exp=op[w]; set gnt[w]=1; set s=op[w] and r=~op[w]; move to DRIVE.
- DRIVE (cycle k..k+1):
  - gnt and s/r high for this single cycle; the flop captures at edge k+1.
  - At edge k+1: gnt=0, s=0, r=0; move to CHECK.
- CHECK (cycle k+1..k+2):
  - At edge k+2: sample q_in and compare with exp.
  - Mismatch sets err=1 (sticky). The transaction still completes.
  - Assert ack[owner]=1 for one cycle. Pointer = (owner+1) mod NREQ. Move to IDLE.
- Latency: request seen at edge k -> ack high during cycle k+2..k+3.
  - Minimum spacing between grants is 3 cycles.
  - busy is high from edge k until edge k+2.
- Invariants: s&r is never 1; gnt and ack are each one-hot or zero; gnt and ack are never high in the same cycle.
- Request rules:
  - req/op are only sampled in IDLE.
  - Changes to req/op while busy are ignored until the next IDLE evaluation.
  - A requester dropping req before its grant is simply not selected.
  - After ack, the requester must drop req in the cycle ack is high, or it re-competes at the next IDLE edge. The pointer has already moved past it, so others are served first.
- Simultaneous requests: resolved by the RR pointer only. op values never affect priority.
- No-op request (op equals current q_in): still fully sequenced (pulse, check, ack). Latency does not change.
- Opposing requests (one set, one reset, pending together): served in RR order; the final flag value is the op of the last-served requester.
- Pointer wrap: after owner=NREQ-1 the pointer returns to 0.

Test Plan:
- Reset check: rst=1 mid-DRIVE with s=1 -> s=r=gnt=ack=busy=err=0 immediately. After release, a req=4'b0001, op=1 is granted to requester 0.
- Single set: req=4'b0100, op[2]=1 at edge 0, flop q=0 -> gnt=4'b0100 and s=1, r=0 in cycle 0..1; q=1 after edge 1; ack=4'b0100 in cycle 2..3; err stays 0.
- Round-robin: req=4'b1111 held, ops alternating -> grant order 0,1,2,3,0, with gnts 3 cycles apart; the flag ends at the op of the last-served requester.
- Conflict safety: req=4'b0011, op=2'b01 (requester 0 sets, requester 1 resets) -> s and r never both 1 on any cycle; q ends 0 after requester 1's ack.
- Readback error: force q_in=0 during CHECK for a set -> err=1 with ack still issued; err stays 1 across further good transactions until rst.
- Withdrawal while busy: requester 3 asserts req, then drops it before IDLE -> no gnt[3], no ack[3]; the pointer only advances for served owners.
